ifetch_queue: RTL and testbench



---
 rtl/venus_if_pkg.sv | 11 +
 rtl/ifetch_queue_if.sv | 31 +++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/ifetch_queue.sv | 76 +++++++
 tb/tb_ifetch_queue.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/venus_if_pkg.sv
// rtl/venus_if_pkg.sv - shared defaults for the instruction fetch path
package venus_if_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int INST_W_DEF = 32;
  localparam int RESET_PC_DEF = 0;

  // Canonical no-op encoding (addi x0, x0, 0) for downstream bubble insertion.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/ifetch_queue_if.sv
// rtl/ifetch_queue_if.sv - memory/redirect/decode signals of the fetch queue
interface ifetch_queue_if #(
  parameter int ADDR_W = 16,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_req_o;
  logic [INST_W-1:0] mem_inst_i;
  logic              branch_i;
  logic [ADDR_W-1:0] branch_addr_i;
  logic              stall_i;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic              inst_valid_o;
  logic [CW-1:0]     count_o;

  modport master (
    output mem_addr_o, mem_req_o, inst_o, inst_addr_o, inst_valid_o, count_o,
    input  mem_inst_i, branch_i, branch_addr_i, stall_i
  );

  modport slave (
    input  mem_addr_o, mem_req_o, inst_o, inst_addr_o, inst_valid_o, count_o,
    output mem_inst_i, branch_i, branch_addr_i, stall_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - registered prefetch FIFO with synchronous flush
module fetch_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);
  assign head    = mem[rd_ptr];

  // Entry storage; contents are don't-care until counted, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; flush empties the queue in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The issue credit scheme upstream must never push into a full queue.
  assert property (@(posedge clk) disable iff (rst) !(do_push && count == FULL));

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - sequential instruction prefetch queue with branch redirect
module ifetch_queue
  import venus_if_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INST_W   = INST_W_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input logic            clk,
  input logic            rst,
  ifetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + INST_W;
  localparam logic [CW:0] CREDIT = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] tag;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic [CW:0]       occupancy;
  logic              valid;
  logic              issue;
  logic              push;
  logic              pop;

  // Queued plus in-flight entries; a same-cycle pop deliberately earns no credit.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign valid     = (count != '0);
  assign issue     = !rst && !bus.branch_i && (occupancy < CREDIT);
  assign push      = inflight && !bus.branch_i;
  assign pop       = valid && !bus.stall_i && !bus.branch_i;

  // Fetch PC and the single tracked read; a redirect cancels whatever is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      tag      <= '0;
      inflight <= 1'b0;
    end else if (bus.branch_i) begin
      fetch_pc <= bus.branch_addr_i;
      inflight <= 1'b0;
    end else if (issue) begin
      tag      <= fetch_pc;
      inflight <= 1'b1;
      fetch_pc <= fetch_pc + ADDR_W'(1);
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.branch_i),
    .push  (push),
    .din   ({tag, bus.mem_inst_i}),
    .pop   (pop),
    .count (count),
    .head  (head)
  );

  assign bus.mem_addr_o   = fetch_pc;
  assign bus.mem_req_o    = issue;
  assign bus.inst_valid_o = valid;
  assign bus.count_o      = count;
  assign bus.inst_addr_o  = valid ? head[EW-1:INST_W] : '0;
  assign bus.inst_o       = valid ? head[INST_W-1:0]  : '0;

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - randomized model-checked bench for ifetch_queue
module tb_ifetch_queue;

  localparam int ADDR_W = 16;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst;

  ifetch_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) ifc ();

  ifetch_queue #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .DEPTH    (DEPTH),
    .RESET_PC (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: M[a] = C0DE0000 | a, one-cycle synchronous read.
  always @(posedge clk) ifc.mem_inst_i <= 32'hC0DE_0000 | {16'h0, ifc.mem_addr_o};

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [15:0] m_q[$];
  logic [15:0] m_pc;
  int          m_infl;
  logic [15:0] m_tag;
  logic [15:0] popped[$];

  logic        s_valid, s_req;
  logic [15:0] s_iaddr, s_addr;
  logic [31:0] s_inst;
  logic [2:0]  s_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc   = 16'h0000;
    m_infl = 0;
    m_tag  = 16'h0000;
  endtask

  // One clock: drive, compare against the model mid-cycle, then advance the model.
  task automatic step(input logic r, input logic b, input logic [15:0] ba, input logic st);
    logic        e_valid, e_req;
    logic [15:0] e_iaddr, e_addr;
    logic [31:0] e_inst;
    int          e_count;
    rst = r;
    ifc.branch_i = b;
    ifc.branch_addr_i = ba;
    ifc.stall_i = st;
    #3;
    s_valid = ifc.inst_valid_o;
    s_req   = ifc.mem_req_o;
    s_iaddr = ifc.inst_addr_o;
    s_addr  = ifc.mem_addr_o;
    s_inst  = ifc.inst_o;
    s_count = ifc.count_o;
    if (r) begin
      model_reset();
      e_valid = 0; e_req = 0; e_iaddr = 0; e_addr = 16'h0000; e_inst = 0; e_count = 0;
    end else begin
      e_count = m_q.size();
      e_valid = (e_count > 0);
      e_iaddr = e_valid ? m_q[0] : 16'h0;
      e_inst  = e_valid ? (32'hC0DE_0000 | {16'h0, m_q[0]}) : 32'h0;
      e_req   = !b && (e_count + m_infl < DEPTH);
      e_addr  = m_pc;
    end
    check("inst_valid", 64'(s_valid), 64'(e_valid));
    check("inst_addr",  64'(s_iaddr), 64'(e_iaddr));
    check("inst",       64'(s_inst),  64'(e_inst));
    check("count",      64'(s_count), 64'(e_count));
    check("mem_req",    64'(s_req),   64'(e_req));
    check("mem_addr",   64'(s_addr),  64'(e_addr));
    if (r) popped.delete();
    else if (s_valid && !st && !b) popped.push_back(s_iaddr);
    @(posedge clk);
    cyc++;
    if (r) begin
      model_reset();
    end else if (b) begin
      m_q.delete();
      m_infl = 0;
      m_pc = ba;
    end else begin
      if (e_valid && !st) void'(m_q.pop_front());
      if (m_infl != 0) begin
        check("no_overflow", 64'(m_q.size() < DEPTH), 64'(1));
        m_q.push_back(m_tag);
      end
      if (e_req) begin
        m_infl = 1;
        m_tag = m_pc;
        m_pc = m_pc + 16'h1;
      end else begin
        m_infl = 0;
      end
    end
    #1;
  endtask

  initial begin
    int maxc;
    rst = 1'b1;
    ifc.branch_i = 0;
    ifc.branch_addr_i = 0;
    ifc.stall_i = 0;
    model_reset();
    @(posedge clk); #1;

    // 1: reset, then first fetch and first valid instruction.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    check("t1_rst_addr", 64'(s_addr), 64'h0);
    check("t1_rst_req", 64'(s_req), 64'h0);
    step(0, 0, 0, 0);
    check("t1_first_req", 64'(s_req), 64'h1);
    check("t1_first_addr", 64'(s_addr), 64'h0000);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("t1_valid", 64'(s_valid), 64'h1);
    check("t1_iaddr", 64'(s_iaddr), 64'h0000);
    check("t1_inst", 64'(s_inst), 64'hC0DE_0000);

    // 2: free-running stream, no gaps or duplicates.
    maxc = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0);
      if (int'(s_count) > maxc) maxc = int'(s_count);
    end
    check("t2_count_le2", 64'(maxc <= 2), 64'h1);
    for (int i = 0; i < 20; i++) check("t2_seq", 64'(popped[i]), 64'(i));

    // 3: stall from reset release; queue fills, head holds, drains in order.
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    check("t3_full", 64'(s_count), 64'd4);
    check("t3_req_off", 64'(s_req), 64'h0);
    check("t3_head", 64'(s_inst), 64'hC0DE_0000);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) check("t3_order", 64'(popped[i]), 64'(i));

    // 4: branch with 3 queued and one read in flight.
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    check("t4_pre_count", 64'(s_count), 64'd2);
    step(0, 1, 16'h0100, 0);
    check("t4_br_count", 64'(s_count), 64'd3);
    popped.delete();
    step(0, 0, 0, 0);
    check("t4_count0", 64'(s_count), 64'd0);
    check("t4_valid0", 64'(s_valid), 64'h0);
    check("t4_addr", 64'(s_addr), 64'h0100);
    check("t4_req", 64'(s_req), 64'h1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("t4_iaddr", 64'(s_iaddr), 64'h0100);
    check("t4_inst", 64'(s_inst), 64'hC0DE_0100);
    step(0, 0, 0, 0);
    check("t4_next", 64'(s_iaddr), 64'h0101);
    check("t4_no_stale", 64'(popped.size() > 0 ? popped[0] : 16'hDEAD), 64'h0100);

    // 5: branch + stall + arriving response; branch wins.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    popped.delete();
    step(0, 1, 16'h0200, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    check("t5_first", 64'(popped.size() > 0 ? popped[0] : 16'hDEAD), 64'h0200);

    // 6: wrap-around, then async reset mid-stream.
    popped.delete();
    step(0, 1, 16'hFFFE, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    check("t6_w0", 64'(popped.size() > 0 ? popped[0] : 16'hDEAD), 64'hFFFE);
    check("t6_w1", 64'(popped.size() > 1 ? popped[1] : 16'hDEAD), 64'hFFFF);
    check("t6_w2", 64'(popped.size() > 2 ? popped[2] : 16'hDEAD), 64'h0000);
    rst = 1'b1;
    #1;
    check("t6_async_valid", 64'(ifc.inst_valid_o), 64'h0);
    check("t6_async_count", 64'(ifc.count_o), 64'h0);
    check("t6_async_addr", 64'(ifc.mem_addr_o), 64'h0000);
    check("t6_async_req", 64'(ifc.mem_req_o), 64'h0);
    check("t6_async_iaddr", 64'(ifc.inst_addr_o), 64'h0);
    #1;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("t6_restart_addr", 64'(s_addr), 64'h0000);
    check("t6_restart_req", 64'(s_req), 64'h1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("t6_restart_iaddr", 64'(s_iaddr), 64'h0000);

    // Random phase against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 99) < 7,
           16'($urandom),
           $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
